// File: rtl/gtxe2_chnl_bond.sv
`default_nettype none
// ============================================================================
// gtxe2_chnl_bond : RX channel bonding / deskew for LANES gtxe2 lanes on RXUSRCLK2
// Revision: 1.0
// ============================================================================
module gtxe2_chnl_bond #(
    parameter int         LANES     = 4,
    parameter int         BYTES     = 2,
    parameter int         DEPTH     = 8,
    parameter int         MAX_SKEW  = 6,
    parameter logic [7:0] BOND_CHAR = 8'h7C
) (
    input  logic                          RXUSRCLK2,
    input  logic                          reset_n,
    input  logic                          BOND_EN,
    input  logic [LANES-1:0]              RXBYTEISALIGNED,
    input  logic [LANES*BYTES*8-1:0]      RXDATA_IN,
    input  logic [LANES*BYTES-1:0]        RXCHARISK_IN,
    output logic [LANES*BYTES*8-1:0]      RXDATA_OUT,
    output logic [LANES*BYTES-1:0]        RXCHARISK_OUT,
    output logic                          RXVALID_OUT,
    output logic                          BONDED,
    output logic                          BOND_ERR,
    output logic [LANES*$clog2(DEPTH)-1:0] LANE_SKEW
);

    localparam int SW = $clog2(DEPTH);
    localparam int DW = BYTES * 8;
    localparam int WW = DW + BYTES;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HUNT   = 2'd1,
        S_ALIGN  = 2'd2,
        S_BONDED = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [SW-1:0]            wr_ptr_q;
    logic [LANES-1:0][SW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LANES-1:0][SW-1:0] cap_q, cap_d;
    logic [LANES-1:0][SW-1:0] skew_q, skew_d;
    logic [LANES-1:0]         seen_q, seen_d;
    logic [SW-1:0]            cnt_q, cnt_d;
    logic [LANES*DW-1:0]      dout_q, dout_d;
    logic [LANES*BYTES-1:0]   kout_q, kout_d;
    logic                     err_q, err_d;

    logic [LANES-1:0]         mark_in, mark_rd, cap_now;
    logic [LANES-1:0][WW-1:0] rd_word;
    logic [LANES*DW-1:0]      ld_data;
    logic [LANES*BYTES-1:0]   ld_k;
    logic [SW-1:0]            cap_val;
    logic                     lost;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic [WW-1:0] mem_q [DEPTH];

            always_ff @(posedge RXUSRCLK2) begin
                mem_q[wr_ptr_q] <= {RXCHARISK_IN[i*BYTES +: BYTES], RXDATA_IN[i*DW +: DW]};
            end

            assign rd_word[i]                 = mem_q[rd_ptr_q[i]];
            assign ld_data[i*DW +: DW]        = rd_word[i][DW-1:0];
            assign ld_k[i*BYTES +: BYTES]     = rd_word[i][DW +: BYTES];
            assign mark_in[i] = RXCHARISK_IN[i*BYTES] && (RXDATA_IN[i*DW +: 8] == BOND_CHAR);
            assign mark_rd[i] = rd_word[i][DW] && (rd_word[i][7:0] == BOND_CHAR);
            assign LANE_SKEW[i*SW +: SW]      = skew_q[i];
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        cap_d    = cap_q;
        skew_d   = skew_q;
        seen_d   = seen_q;
        cnt_d    = cnt_q;
        dout_d   = '0;
        kout_d   = '0;
        err_d    = 1'b0;
        lost     = !BOND_EN || !(&RXBYTEISALIGNED);
        cap_now  = mark_in & ~seen_q;
        // The skew counter only runs once some lane has been captured.
        cap_val  = (|seen_q) ? cnt_q : '0;

        case (state_q)
            S_IDLE: begin
                seen_d = '0;
                cnt_d  = '0;
                if (!lost) state_d = S_HUNT;
            end
            S_HUNT: begin
                for (int i = 0; i < LANES; i++) begin
                    if (cap_now[i]) begin
                        rd_ptr_d[i] = wr_ptr_q;
                        cap_d[i]    = cap_val;
                    end
                end
                seen_d = seen_q | cap_now;
                if (&seen_d) begin
                    state_d = S_ALIGN;
                    for (int i = 0; i < LANES; i++) skew_d[i] = cap_val - cap_d[i];
                end else if ((|seen_q) && (cnt_q >= SW'(MAX_SKEW))) begin
                    err_d  = 1'b1;
                    seen_d = '0;
                    cnt_d  = '0;
                end else if (|seen_d) begin
                    cnt_d = cap_val + SW'(1);
                end
            end
            S_ALIGN: begin
                state_d = S_BONDED;
                dout_d  = ld_data;
                kout_d  = ld_k;
                for (int i = 0; i < LANES; i++) rd_ptr_d[i] = rd_ptr_q[i] + SW'(1);
            end
            default: begin
                if ((|mark_rd) && !(&mark_rd)) begin
                    err_d   = 1'b1;
                    state_d = S_HUNT;
                    seen_d  = '0;
                    cnt_d   = '0;
                end else begin
                    dout_d = ld_data;
                    kout_d = ld_k;
                    for (int i = 0; i < LANES; i++) rd_ptr_d[i] = rd_ptr_q[i] + SW'(1);
                end
            end
        endcase

        // Lane loss overrides everything, including a pending marker error.
        if (lost) begin
            state_d = S_IDLE;
            err_d   = 1'b0;
            dout_d  = '0;
            kout_d  = '0;
            seen_d  = '0;
            cnt_d   = '0;
            skew_d  = skew_q;
        end
    end

    always_ff @(posedge RXUSRCLK2 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cap_q    <= '0;
            skew_q   <= '0;
            seen_q   <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            kout_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_q + SW'(1);
            rd_ptr_q <= rd_ptr_d;
            cap_q    <= cap_d;
            skew_q   <= skew_d;
            seen_q   <= seen_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            kout_q   <= kout_d;
            err_q    <= err_d;
        end
    end

    assign RXDATA_OUT    = dout_q;
    assign RXCHARISK_OUT = kout_q;
    assign BONDED        = (state_q == S_BONDED);
    assign RXVALID_OUT   = (state_q == S_BONDED);
    assign BOND_ERR      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_gtxe2_chnl_bond.sv
`default_nettype none
// tb_gtxe2_chnl_bond : directed + random bench for gtxe2_chnl_bond against a
// cycle-indexed reference model (input history + capture cycle numbers).
module tb_gtxe2_chnl_bond;

    localparam int MAX_SKEW = 6;
    localparam int M_IDLE = 0, M_HUNT = 1, M_ALIGN = 2, M_BONDED = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic [3:0]  al;
    logic [63:0] rxd;
    logic [7:0]  rxk;
    logic [63:0] RXDATA_OUT;
    logic [7:0]  RXCHARISK_OUT;
    logic        RXVALID_OUT, BONDED, BOND_ERR;
    logic [11:0] LANE_SKEW;

    logic [15:0] din [4];
    logic [1:0]  kin [4];
    logic [15:0] hd [4][2048];
    logic [1:0]  hk [4][2048];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int ms, first_c, kk;
    int capc [4];
    int sk   [4];
    logic [63:0] e_data;
    logic [7:0]  e_k;
    logic        e_bonded, e_err;
    logic [11:0] e_skew;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rxd[i*16 +: 16] = din[i];
            rxk[i*2 +: 2]   = kin[i];
        end
    end

    gtxe2_chnl_bond #(
        .LANES(4), .BYTES(2), .DEPTH(8), .MAX_SKEW(MAX_SKEW), .BOND_CHAR(8'h7C)
    ) dut (
        .RXUSRCLK2      (clk),
        .reset_n        (reset_n),
        .BOND_EN        (en),
        .RXBYTEISALIGNED(al),
        .RXDATA_IN      (rxd),
        .RXCHARISK_IN   (rxk),
        .RXDATA_OUT     (RXDATA_OUT),
        .RXCHARISK_OUT  (RXCHARISK_OUT),
        .RXVALID_OUT    (RXVALID_OUT),
        .BONDED         (BONDED),
        .BOND_ERR       (BOND_ERR),
        .LANE_SKEW      (LANE_SKEW)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit is_mark(input logic [15:0] d, input logic [1:0] k);
        return k[0] && (d[7:0] == 8'h7C);
    endfunction

    task automatic clear_caps();
        for (int i = 0; i < 4; i++) capc[i] = -1;
        first_c = -1;
    endtask

    task automatic model_reset();
        ms = M_IDLE;
        kk = 0;
        clear_caps();
        for (int i = 0; i < 4; i++) sk[i] = 0;
        e_data = '0; e_k = '0; e_bonded = 1'b0; e_err = 1'b0; e_skew = '0;
    endtask

    task automatic load_words(input int k);
        for (int i = 0; i < 4; i++) begin
            e_data[i*16 +: 16] = hd[i][capc[i] + k];
            e_k[i*2 +: 2]      = hk[i][capc[i] + k];
        end
    endtask

    // Expected outputs for the cycle after cycle c, from the bonding rules.
    task automatic model_next(input int c);
        bit lost, done;
        int nsk [4];
        int latest, nm;
        lost = !en || (al != 4'hF);
        done = 1'b0;
        e_err = 1'b0; e_data = '0; e_k = '0;
        case (ms)
            M_IDLE: if (!lost) begin ms = M_HUNT; clear_caps(); end
            M_HUNT: begin
                for (int i = 0; i < 4; i++)
                    if (capc[i] < 0 && is_mark(hd[i][c], hk[i][c])) begin
                        capc[i] = c;
                        if (first_c < 0) first_c = c;
                    end
                done = 1'b1; latest = 0;
                for (int i = 0; i < 4; i++) begin
                    if (capc[i] < 0) done = 1'b0;
                    else if (capc[i] > latest) latest = capc[i];
                end
                if (done) begin
                    for (int i = 0; i < 4; i++) nsk[i] = latest - capc[i];
                    ms = M_ALIGN;
                end else if (first_c >= 0 && (c - first_c) >= MAX_SKEW) begin
                    e_err = 1'b1;
                    clear_caps();
                end
            end
            M_ALIGN: begin load_words(0); kk = 1; ms = M_BONDED; end
            default: begin
                nm = 0;
                for (int i = 0; i < 4; i++)
                    nm += int'(is_mark(hd[i][capc[i] + kk], hk[i][capc[i] + kk]));
                if (nm > 0 && nm < 4) begin
                    e_err = 1'b1; ms = M_HUNT; clear_caps();
                end else begin
                    load_words(kk); kk++;
                end
            end
        endcase
        if (lost) begin
            ms = M_IDLE; e_err = 1'b0; e_data = '0; e_k = '0;
        end else if (done) begin
            for (int i = 0; i < 4; i++) sk[i] = nsk[i];
        end
        e_bonded = (ms == M_BONDED);
        e_skew = {3'(sk[3]), 3'(sk[2]), 3'(sk[1]), 3'(sk[0])};
    endtask

    task automatic compare_all();
        chk("data",    RXDATA_OUT,            e_data);
        chk("charisk", 64'(RXCHARISK_OUT),    64'(e_k));
        chk("bonded",  64'(BONDED),           64'(e_bonded));
        chk("valid",   64'(RXVALID_OUT),      64'(e_bonded));
        chk("err",     64'(BOND_ERR),         64'(e_err));
        chk("skew",    64'(LANE_SKEW),        64'(e_skew));
    endtask

    task automatic rand_in(input logic [3:0] m);
        for (int i = 0; i < 4; i++) begin
            din[i] = 16'($urandom);
            kin[i] = 2'($urandom);
            if (din[i][7:0] == 8'h7C) din[i][7:0] = 8'h3C;
            if (m[i]) begin
                din[i][7:0] = 8'h7C;
                kin[i][0]   = 1'b1;
            end
        end
    endtask

    task automatic step();
        for (int i = 0; i < 4; i++) begin
            hd[i][cyc] = din[i];
            hk[i][cyc] = kin[i];
        end
        model_next(cyc);
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic run(input int n);
        repeat (n) begin rand_in(4'h0); step(); end
    endtask

    task automatic mark(input logic [3:0] m);
        rand_in(m);
        step();
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b0; al = 4'h0;
        rand_in(4'h0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        reset_n = 1'b1; en = 1'b1; al = 4'hF;
        run(3);

        // Staggered markers: lanes 0,1,3,2 in consecutive cycles.
        mark(4'b0001); mark(4'b0010); mark(4'b1000); mark(4'b0100);
        chk("t1_skew", 64'(LANE_SKEW), 64'h213);
        chk("t1_not_bonded", 64'(BONDED), 64'd0);
        run(1);
        chk("t1_bonded", 64'(BONDED), 64'd1);
        for (int i = 0; i < 4; i++) chk("t1_marker", 64'(RXDATA_OUT[i*16 +: 8]), 64'h7C);
        run(20);

        // Simultaneous markers, long run across pointer wrap.
        en = 1'b0; run(1); en = 1'b1; run(2);
        mark(4'hF);
        chk("t2_skew", 64'(LANE_SKEW), 64'd0);
        run(1);
        chk("t2_bonded", 64'(BONDED), 64'd1);
        chk("t2_marker0", 64'(RXDATA_OUT[7:0]), 64'h7C);
        run(100);

        // Lane 3 missing -> hunt timeout, then a normal bond.
        en = 1'b0; run(1); en = 1'b1; run(2);
        mark(4'b0111);
        run(5);
        chk("t3_no_err_yet", 64'(BOND_ERR), 64'd0);
        run(1);
        chk("t3_timeout", 64'(BOND_ERR), 64'd1);
        chk("t3_not_bonded", 64'(BONDED), 64'd0);
        run(1);
        chk("t3_err_pulse", 64'(BOND_ERR), 64'd0);
        run(2);
        mark(4'b1000); mark(4'b0111);
        run(10);
        chk("t3_rebond", 64'(BONDED), 64'd1);
        chk("t3_skew", 64'(LANE_SKEW), 64'h200);

        // Single-lane marker while bonded.
        mark(4'b0010);
        run(1);
        chk("t4_err", 64'(BOND_ERR), 64'd1);
        chk("t4_unbonded", 64'(BONDED), 64'd0);
        chk("t4_data_zero", RXDATA_OUT, 64'd0);
        run(3);
        mark(4'hF);
        run(5);
        chk("t4_rebond", 64'(BONDED), 64'd1);

        // Lane lock loss, then async reset mid-bond.
        al = 4'b1011;
        run(1);
        chk("t5_loss", 64'(BONDED), 64'd0);
        chk("t5_no_err", 64'(BOND_ERR), 64'd0);
        al = 4'hF;
        run(2);
        mark(4'b0001); mark(4'b1110);
        run(6);
        chk("t5_bonded", 64'(BONDED), 64'd1);
        chk("t5_skew", 64'(LANE_SKEW), 64'h001);
        reset_n = 1'b0;
        #2;
        chk("rst_bonded", 64'(BONDED), 64'd0);
        chk("rst_valid",  64'(RXVALID_OUT), 64'd0);
        chk("rst_data",   RXDATA_OUT, 64'd0);
        chk("rst_k",      64'(RXCHARISK_OUT), 64'd0);
        chk("rst_skew",   64'(LANE_SKEW), 64'd0);
        chk("rst_err",    64'(BOND_ERR), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        cyc++;
        run(3);
        mark(4'hF);
        run(4);

        // Random markers, lane subsets and occasional loss.
        for (int n = 0; n < 400; n++) begin
            int r;
            r  = $urandom_range(0, 99);
            en = ($urandom_range(0, 59) != 0);
            al = 4'hF;
            if ($urandom_range(0, 59) == 0) al[$urandom_range(0, 3)] = 1'b0;
            if (r < 8)       rand_in(4'($urandom_range(1, 15)));
            else if (r < 16) rand_in(4'hF);
            else             rand_in(4'h0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
